// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: owns the byte-wide memory bus, streams code bytes
// into a circular buffer, and yields the bus to core data accesses.
module prefetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [19:0]   flush_addr,
    input  logic          q_rd,
    output logic [7:0]    q_data,
    output logic          q_valid,
    output logic [AW:0]   q_count,
    output logic [19:0]   q_addr,
    input  logic          dmem_req,
    input  logic [19:0]   dmem_addr,
    input  logic          dmem_wren,
    input  logic [7:0]    dmem_out,
    output logic [7:0]    dmem_rdata,
    output logic [19:0]   mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_wren,
    input  logic [7:0]    mem_rdata
);

    localparam int CW = AW + 2;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pending_q, pending_d;
    logic [19:0]   fetch_addr_q, fetch_addr_d;
    logic [19:0]   q_addr_q, q_addr_d;
    logic [7:0]    fifo_q [DEPTH];

    logic [CW-1:0] occupancy;
    logic          issue;
    logic          capture;
    logic          pop;

    // Occupancy counts the in-flight byte so the buffer can never overflow.
    assign occupancy = {1'b0, count_q} + CW'(pending_q);
    assign issue     = !flush && !dmem_req && (occupancy < CW'(DEPTH));
    assign capture   = pending_q && !flush;
    assign pop       = q_rd && q_valid && !flush;

    assign q_valid    = (count_q != '0);
    assign q_count    = count_q;
    assign q_addr     = q_addr_q;
    assign q_data     = fifo_q[rd_ptr_q];
    assign dmem_rdata = mem_rdata;

    always_comb begin
        mem_addr  = fetch_addr_q;
        mem_wdata = 8'h00;
        mem_wren  = 1'b0;
        if (dmem_req) begin
            mem_addr  = dmem_addr;
            mem_wdata = dmem_out;
            mem_wren  = dmem_wren;
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        pending_d    = issue;
        fetch_addr_d = fetch_addr_q;
        q_addr_d     = q_addr_q;
        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = flush_addr;
            q_addr_d     = flush_addr;
        end else begin
            if (issue)
                fetch_addr_d = fetch_addr_q + 20'd1;
            if (capture)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                q_addr_d = q_addr_q + 20'd1;
            end
            case ({capture, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            fetch_addr_q <= 20'hFFFF0;
            q_addr_q     <= 20'hFFFF0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            fetch_addr_q <= fetch_addr_d;
            q_addr_q     <= q_addr_d;
        end
    end

    // Data storage needs no reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (capture)
            fifo_q[wr_ptr_q] <= mem_rdata;
    end

endmodule
